pad_input_conditioner: RTL

Per-pad input conditioning stage that sits directly downstream of the input pad cells and consumes their `pad_out_o` values before they reach GPIO/peripheral logic. It synchronizes each asynchronous pad value into the `clk_i` domain and applies a programmable per-pad glitch filter (debounce). It produces a clean level per pad plus single-cycle rise/fall event pulses for the interrupt and wake-up logic.

---
 rtl/pad_input_conditioner.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pad_input_conditioner.sv
// Per-pad input conditioning: synchronizes raw pad values into clk_i and applies a
// programmable glitch filter, producing a clean level plus rise/fall event pulses.
module pad_input_conditioner #(
  parameter int N_PADS      = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_PADS-1:0] pad_i,
  input  logic [N_PADS-1:0] debounce_en_i,
  input  logic [CNT_W-1:0]  debounce_cycles_i,
  input  logic [N_PADS-1:0] rise_en_i,
  input  logic [N_PADS-1:0] fall_en_i,
  output logic [N_PADS-1:0] level_o,
  output logic [N_PADS-1:0] pending_o,
  output logic [N_PADS-1:0] rise_o,
  output logic [N_PADS-1:0] fall_o,
  output logic              event_o
);

  typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_e;

  logic [N_PADS-1:0] sync_q [SYNC_STAGES];
  logic [N_PADS-1:0] s;

  state_e           state_q [N_PADS];
  state_e           state_d [N_PADS];
  logic [CNT_W-1:0] cnt_q   [N_PADS];
  logic [CNT_W-1:0] cnt_d   [N_PADS];
  logic [CNT_W-1:0] thr_eff [N_PADS];
  logic [CNT_W:0]   cnt_inc [N_PADS];

  logic [N_PADS-1:0] level_q, level_d;
  logic [N_PADS-1:0] rise_q, rise_d;
  logic [N_PADS-1:0] fall_q, fall_d;
  logic [N_PADS-1:0] commit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Counter is one wider on the increment so the threshold compare can never wrap.
  always_comb begin
    for (int i = 0; i < N_PADS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      commit[i]  = 1'b0;
      thr_eff[i] = (debounce_en_i[i] && (debounce_cycles_i > CNT_W'(1)))
                   ? debounce_cycles_i : CNT_W'(1);
      cnt_inc[i] = {1'b0, cnt_q[i]} + (CNT_W+1)'(1);

      case (state_q[i])
        STABLE: begin
          if (s[i] != level_q[i]) begin
            if (thr_eff[i] == CNT_W'(1)) begin
              commit[i] = 1'b1;
            end else begin
              cnt_d[i]   = CNT_W'(1);
              state_d[i] = PENDING;
            end
          end
        end
        PENDING: begin
          if (s[i] == level_q[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = STABLE;
          end else if (cnt_inc[i] >= {1'b0, thr_eff[i]}) begin
            commit[i]  = 1'b1;
            cnt_d[i]   = '0;
            state_d[i] = STABLE;
          end else begin
            cnt_d[i] = cnt_inc[i][CNT_W-1:0];
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = STABLE;
        end
      endcase
    end

    level_d = (level_q & ~commit) | (s & commit);
    rise_d  = commit & s & rise_en_i;
    fall_d  = commit & ~s & fall_en_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_PADS; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      for (int i = 0; i < N_PADS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < N_PADS; i++) pending_o[i] = (state_q[i] == PENDING);
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = |{rise_q, fall_q};

endmodule
